// File: rtl/hz_pkg.sv
// Shared constants and slot bundle for the hazard/forwarding controller.
// Also holds the small field-update helpers used by the top.
package hz_pkg;

  localparam logic [2:0] SEL_RF = 3'd0;
  localparam logic [2:0] SEL_E  = 3'd1;
  localparam logic [2:0] SEL_M  = 3'd2;
  localparam logic [2:0] SEL_W  = 3'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_E = 2'd0;
  localparam logic [1:0] TNEW_M = 2'd1;
  localparam logic [1:0] TNEW_W = 2'd2;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{
    wa:      5'd0,
    tnew:    2'd0,
    rs:      5'd0,
    rt:      5'd0,
    tuse_rs: TUSE_NONE,
    tuse_rt: TUSE_NONE
  };

  function automatic logic [1:0] dec_sat(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  // An unused operand stays unused as it moves down the pipe.
  function automatic logic [1:0] dec_tuse(input logic [1:0] x);
    return (x == TUSE_NONE) ? TUSE_NONE : dec_sat(x);
  endfunction

  function automatic logic hit(
    input logic [4:0] wa,
    input logic [4:0] r
  );
    return (r != 5'd0) && (wa == r);
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide occupancy counter.
// Loads the unit latency on start, counts down to idle.
module md_busy_ctr #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LMUL = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] LDIV = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt;

  // Load on an accepted MD start, otherwise drain toward zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div ? LDIV : LMUL;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and bypass controller for the 5-stage pipeline.
// Tracks E/M/W result latency; drives stall and bypass selects.
module hazard_fwd_ctrl
  import hz_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [2:0] sel_rs_d,
  output logic [2:0] sel_rt_d,
  output logic [2:0] sel_rs_e,
  output logic [2:0] sel_rt_e,
  output logic [2:0] sel_rt_m,
  output logic       md_busy
);

  slot_t e_q, m_q, w_q;
  slot_t d_slot;
  logic  e_md_q;
  logic  issue;
  logic  stall_rs, stall_rt, stall_md;
  logic  unused_fields;

  // Nearest enabled producer wins; it bypasses only once its value exists.
  function automatic logic [2:0] fwd(
    input logic [4:0] r,
    input logic [2:0] en,
    input logic [4:0] e_wa,
    input logic [1:0] e_tn,
    input logic [4:0] m_wa,
    input logic [1:0] m_tn,
    input logic [4:0] w_wa,
    input logic [1:0] w_tn
  );
    logic [2:0] sel;
    sel = SEL_RF;
    if (en[0] && hit(e_wa, r)) begin
      sel = (e_tn == 2'd0) ? SEL_E : SEL_RF;
    end else if (en[1] && hit(m_wa, r)) begin
      sel = (m_tn == 2'd0) ? SEL_M : SEL_RF;
    end else if (en[2] && hit(w_wa, r)) begin
      sel = (w_tn == 2'd0) ? SEL_W : SEL_RF;
    end
    return sel;
  endfunction

  // Stall when the nearest producer is later than the consumer needs it.
  function automatic logic src_stall(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tn,
    input logic [4:0] m_wa,
    input logic [1:0] m_tn
  );
    logic s;
    s = 1'b0;
    if (tuse != TUSE_NONE) begin
      if (hit(e_wa, r)) begin
        s = (e_tn > tuse);
      end else if (hit(m_wa, r)) begin
        s = (m_tn > tuse);
      end
    end
    return s;
  endfunction

  // D-stage interlock from register and HI/LO hazards.
  always_comb begin
    stall_rs = src_stall(d_rs, d_tuse_rs,
                         e_q.wa, e_q.tnew,
                         m_q.wa, m_q.tnew);
    stall_rt = src_stall(d_rt, d_tuse_rt,
                         e_q.wa, e_q.tnew,
                         m_q.wa, m_q.tnew);
    stall_md = d_md_use &&
               (md_busy || (d_md_start && e_md_q));
    stall    = d_valid &&
               (stall_rs || stall_rt || stall_md);
  end

  // Bypass selects for every reader stage.
  always_comb begin
    sel_rs_d = fwd(d_rs, 3'b111,
                   e_q.wa, e_q.tnew, m_q.wa, m_q.tnew,
                   w_q.wa, w_q.tnew);
    sel_rt_d = fwd(d_rt, 3'b111,
                   e_q.wa, e_q.tnew, m_q.wa, m_q.tnew,
                   w_q.wa, w_q.tnew);
    sel_rs_e = fwd(e_q.rs, 3'b110,
                   e_q.wa, e_q.tnew, m_q.wa, m_q.tnew,
                   w_q.wa, w_q.tnew);
    sel_rt_e = fwd(e_q.rt, 3'b110,
                   e_q.wa, e_q.tnew, m_q.wa, m_q.tnew,
                   w_q.wa, w_q.tnew);
    sel_rt_m = fwd(m_q.rt, 3'b100,
                   e_q.wa, e_q.tnew, m_q.wa, m_q.tnew,
                   w_q.wa, w_q.tnew);
  end

  assign issue = d_valid && !stall;

  // Slot image of the D instruction as it lands in E.
  always_comb begin
    d_slot         = SLOT_BUBBLE;
    d_slot.wa      = d_wa;
    d_slot.tnew    = d_tnew;
    d_slot.rs      = d_rs;
    d_slot.rt      = d_rt;
    d_slot.tuse_rs = dec_tuse(d_tuse_rs);
    d_slot.tuse_rt = dec_tuse(d_tuse_rt);
  end

  // Advance the slot pipe; result latency ages each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q    <= SLOT_BUBBLE;
      m_q    <= SLOT_BUBBLE;
      w_q    <= SLOT_BUBBLE;
      e_md_q <= 1'b0;
    end else begin
      w_q      <= m_q;
      w_q.tnew <= dec_sat(m_q.tnew);
      m_q      <= e_q;
      m_q.tnew <= dec_sat(e_q.tnew);
      e_q      <= issue ? d_slot : SLOT_BUBBLE;
      e_md_q   <= issue && d_md_start;
    end
  end

  md_busy_ctr #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_md (
    .clk  (clk),
    .reset(reset),
    .load (issue && d_md_start),
    .div  (d_md_div),
    .busy (md_busy)
  );

  assign unused_fields = ^{w_q.rs, w_q.rt,
                           w_q.tuse_rs, w_q.tuse_rt};

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl.
// Directed per-cycle vectors; monitor checks each cycle at negedge.
module tb_hazard_fwd_ctrl;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit [1:0] tr, tt;
    bit [4:0] wa;
    bit [1:0] tn;
    bit       ms, md, mu;
    bit       rst;
  } stim_t;

  typedef struct {
    bit [6:0] m;
    bit       st, bz;
    bit [2:0] srd, srtd, sre, srte, srtm;
  } exp_t;

  localparam bit [6:0] ST  = 7'h01;
  localparam bit [6:0] BZ  = 7'h02;
  localparam bit [6:0] RSD = 7'h04;
  localparam bit [6:0] RTD = 7'h08;
  localparam bit [6:0] RSE = 7'h10;
  localparam bit [6:0] RTE = 7'h20;
  localparam bit [6:0] RTM = 7'h40;
  localparam bit [6:0] ALL = 7'h7f;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [2:0] sel_rs_d, sel_rt_d;
  logic [2:0] sel_rs_e, sel_rt_e, sel_rt_m;

  exp_t  eq[$];
  string nq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_wa      (d_wa),
    .d_tnew    (d_tnew),
    .d_md_start(d_md_start),
    .d_md_div  (d_md_div),
    .d_md_use  (d_md_use),
    .stall     (stall),
    .sel_rs_d  (sel_rs_d),
    .sel_rt_d  (sel_rt_d),
    .sel_rs_e  (sel_rs_e),
    .sel_rt_e  (sel_rt_e),
    .sel_rt_m  (sel_rt_m),
    .md_busy   (md_busy)
  );

  function automatic stim_t op(
    input bit [4:0] wa, input bit [1:0] tn,
    input bit [4:0] rs, input bit [1:0] tr,
    input bit [4:0] rt, input bit [1:0] tt
  );
    stim_t s;
    s.v = 1'b1; s.wa = wa; s.tn = tn;
    s.rs = rs; s.tr = tr; s.rt = rt; s.tt = tt;
    s.ms = 1'b0; s.md = 1'b0; s.mu = 1'b0;
    s.rst = 1'b0;
    return s;
  endfunction

  function automatic stim_t bub();
    stim_t s;
    s = op(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    s.v = 1'b0;
    return s;
  endfunction

  function automatic exp_t X(
    input bit [6:0] m, input bit st, input bit bz,
    input bit [2:0] srd, input bit [2:0] srtd,
    input bit [2:0] sre, input bit [2:0] srte,
    input bit [2:0] srtm
  );
    exp_t e;
    e.m = m; e.st = st; e.bz = bz;
    e.srd = srd; e.srtd = srtd; e.sre = sre;
    e.srte = srte; e.srtm = srtm;
    return e;
  endfunction

  task automatic cyc(input string nm, input stim_t s,
                     input exp_t e);
    reset      = s.rst;
    d_valid    = s.v;
    d_rs       = s.rs;
    d_rt       = s.rt;
    d_tuse_rs  = s.tr;
    d_tuse_rt  = s.tt;
    d_wa       = s.wa;
    d_tnew     = s.tn;
    d_md_start = s.ms;
    d_md_div   = s.md;
    d_md_use   = s.mu;
    eq.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input string f,
                     input logic [2:0] a, input bit [2:0] x);
    n_chk++;
    if (a !== {1'b0, x} [2:0]) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d",
               nm, f, a, x);
    end
  endtask

  // Monitor: pop the expectation issued for this cycle and compare.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (eq.size() != 0) begin
      e = eq.pop_front();
      n = nq.pop_front();
      if (e.m[0]) chk(n, "stall", {2'b0, stall}, {2'b0, e.st});
      if (e.m[1]) chk(n, "md_busy", {2'b0, md_busy}, {2'b0, e.bz});
      if (e.m[2]) chk(n, "sel_rs_d", sel_rs_d, e.srd);
      if (e.m[3]) chk(n, "sel_rt_d", sel_rt_d, e.srtd);
      if (e.m[4]) chk(n, "sel_rs_e", sel_rs_e, e.sre);
      if (e.m[5]) chk(n, "sel_rt_e", sel_rt_e, e.srte);
      if (e.m[6]) chk(n, "sel_rt_m", sel_rt_m, e.srtm);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, mfhi, dv, ml;
    exp_t  none;
    none = X(7'h00, 0, 0, 0, 0, 0, 0, 0);
    mfhi = op(11, 1, 0, 3, 0, 3);
    mfhi.mu = 1'b1;
    dv = op(0, 0, 1, 0, 2, 0);
    dv.ms = 1'b1; dv.md = 1'b1; dv.mu = 1'b1;
    ml = dv;
    ml.md = 1'b0;

    s = bub();
    s.rst = 1'b1;
    reset = 1'b1;
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_wa = '0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_tnew = '0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cyc("reset_state", bub(), X(ALL, 0, 0, 0, 0, 0, 0, 0));

    cyc("alu_issue", op(3, 1, 1, 1, 2, 1), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_stall", op(0, 0, 3, 0, 0, 0), X(ST | RSD, 1, 0, 0, 0, 0, 0, 0));
    cyc("beq_go", op(0, 0, 3, 0, 0, 0), X(ST | RSD | RSE, 0, 0, 2, 0, 0, 0, 0));
    cyc("beq_in_e", bub(), X(RSE, 0, 0, 0, 0, 3, 0, 0));

    cyc("lw_issue", op(5, 2, 29, 1, 0, 3), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("ldu_stall", op(7, 1, 5, 1, 6, 1), X(ST, 1, 0, 0, 0, 0, 0, 0));
    cyc("ldu_go", op(7, 1, 5, 1, 6, 1), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("ldu_in_e", bub(), X(RSE | RTE, 0, 0, 0, 0, 3, 0, 0));

    cyc("jal_issue", op(31, 0, 0, 3, 0, 3), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("jr_d", op(0, 0, 31, 0, 0, 3), X(ST | RSD, 0, 0, 1, 0, 0, 0, 0));
    cyc("jr_in_e", bub(), X(RSE, 0, 0, 0, 0, 2, 0, 0));

    cyc("lw8_issue", op(8, 2, 29, 1, 0, 3), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("unrel", op(9, 1, 1, 1, 2, 1), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_d", op(0, 0, 29, 1, 8, 2), X(ST | RTD, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_in_e", bub(), X(RSE | RTE, 0, 0, 0, 0, 0, 3, 0));
    cyc("sw_in_m", bub(), X(RTM, 0, 0, 0, 0, 0, 0, 0));

    cyc("lw8b_issue", op(8, 2, 29, 1, 0, 3), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw2_d", op(0, 0, 29, 1, 8, 2), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw2_in_e", bub(), X(RTE, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw2_in_m", bub(), X(RTM, 0, 0, 0, 0, 0, 0, 3));

    cyc("ori_r0", op(0, 1, 0, 1, 0, 3), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("use_r0", op(0, 0, 0, 0, 0, 0), X(ST | RSD | RTD, 0, 0, 0, 0, 0, 0, 0));

    cyc("pri_a", op(4, 1, 1, 1, 2, 1), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("pri_b", op(4, 0, 0, 3, 0, 3), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("pri_fwd_e", op(0, 0, 4, 0, 0, 3), X(ST | RSD, 0, 0, 1, 0, 0, 0, 0));
    cyc("pri_c", op(10, 1, 1, 1, 2, 1), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("pri_d", op(10, 1, 1, 1, 2, 1), X(ST, 0, 0, 0, 0, 0, 0, 0));
    cyc("pri_stall_e", op(0, 0, 10, 0, 0, 3), X(ST | RSD, 1, 0, 0, 0, 0, 0, 0));
    cyc("pri_go_m", op(0, 0, 10, 0, 0, 3), X(ST | RSD, 0, 0, 2, 0, 0, 0, 0));

    cyc("div_issue", dv, X(ST | BZ, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      cyc("mfhi_wait", mfhi, X(ST | BZ, 1, 1, 0, 0, 0, 0, 0));
    cyc("mfhi_go", mfhi, X(ST | BZ, 0, 0, 0, 0, 0, 0, 0));

    cyc("mult_issue", ml, X(ST | BZ, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      cyc("div_held", dv, X(ST | BZ, 1, 1, 0, 0, 0, 0, 0));
    cyc("div_go", dv, X(ST | BZ, 0, 0, 0, 0, 0, 0, 0));

    cyc("div_run10", bub(), X(BZ, 0, 1, 0, 0, 0, 0, 0));
    cyc("div_run9", bub(), X(BZ, 0, 1, 0, 0, 0, 0, 0));
    cyc("div_run8", op(12, 1, 1, 1, 0, 3), X(BZ, 0, 1, 0, 0, 0, 0, 0));
    s = op(3, 1, 12, 0, 0, 3);
    s.rst = 1'b1;
    cyc("rst_cnt7", s, X(ST | BZ, 1, 1, 0, 0, 0, 0, 0));
    s = op(0, 0, 12, 0, 3, 0);
    s.mu = 1'b1;
    cyc("post_rst", s, X(ALL, 0, 0, 0, 0, 0, 0, 0));
    cyc("post_rst2", bub(), X(BZ | RSE | RTE, 0, 0, 0, 0, 0, 0, 0));
    cyc("tail", bub(), none);

    for (int i = 0; i < 10 && eq.size() != 0; i++)
      @(negedge clk);
    if (eq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", eq.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
